// File: rtl/pal_macrocell.sv
// Serially configured AND/OR array with per-output macrocells and a framed loader.
// Optional readback of the previous frame on CFG_OUT: define PAL_MACROCELL_READBACK_EN.
module pal_macrocell #(
  parameter int N = 8,
  parameter int P = 8,
  parameter int M = 8
) (
  input  logic         CLK,
  input  logic         RES_N,
  input  logic         CFG_START,
  input  logic         CFG_VALID,
  input  logic         CFG_BIT,
  input  logic [N-1:0] INPUT_VARS,
  output logic [M-1:0] OUTPUT_VALS,
  output logic         CFG_BUSY,
  output logic         CFG_DONE,
  output logic [1:0]   DBG_STATE
`ifdef PAL_MACROCELL_READBACK_EN
  ,
  output logic         CFG_OUT
`endif
);

  localparam int L  = 2*N*P + P*M + 2*M;
  localparam int A  = 2*N*P;
  localparam int B  = A + P*M;
  localparam int CW = $clog2(L+1);
  localparam logic [CW-1:0] LAST = CW'(L-1);

  // Handshake: a configuration bit is consumed on any rising CLK where the
  // loader is in LOAD, CFG_VALID is high and CFG_START is low; there is no
  // back-pressure, CFG_BUSY only reports that a frame is in progress.
  typedef enum logic [1:0] {S_UNCFG = 2'd0, S_LOAD = 2'd1, S_RUN = 2'd2} state_t;

  state_t         r_state;
  logic [L-1:0]   r_chain;
  logic [CW-1:0]  r_cnt;
  logic [M-1:0]   r_q;
  logic           r_busy;
  logic           r_done;

  logic [2*N-1:0] w_lit;
  logic [P-1:0]   w_any;
  logic [P-1:0]   w_all;
  logic [P-1:0]   w_term;
  logic [M-1:0]   w_sum;
  logic [M-1:0]   w_reg;
  logic [M-1:0]   w_inv;
  logic [M-1:0]   w_comb;

  always_comb begin
    w_lit = '0;
    for (int i = 0; i < N; i++) begin
      w_lit[2*i]   = INPUT_VARS[i];
      w_lit[2*i+1] = ~INPUT_VARS[i];
    end
  end

  // A product term with no connected literal must read 0, hence the w_any qualifier.
  always_comb begin
    w_any = '0;
    w_all = '1;
    for (int p = 0; p < P; p++) begin
      for (int k = 0; k < 2*N; k++) begin
        if (r_chain[p + k*P]) begin
          w_any[p] = 1'b1;
          if (!w_lit[k]) w_all[p] = 1'b0;
        end
      end
    end
    w_term = w_any & w_all;
  end

  always_comb begin
    w_sum = '0;
    w_reg = '0;
    w_inv = '0;
    for (int m = 0; m < M; m++) begin
      w_sum[m] = |(w_term & r_chain[A + m*P +: P]);
      w_reg[m] = r_chain[B + 2*m];
      w_inv[m] = r_chain[B + 2*m + 1];
    end
    w_comb = w_sum ^ w_inv;
  end

  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      r_state <= S_UNCFG;
      r_chain <= '0;
      r_cnt   <= '0;
      r_q     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (CFG_START) begin
      r_state <= S_LOAD;
      r_cnt   <= '0;
      r_q     <= '0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (CFG_VALID) begin
            r_chain <= {r_chain[L-2:0], CFG_BIT};
            if (r_cnt == LAST) begin
              r_state <= S_RUN;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_RUN:   r_q <= w_comb;
        default: ;
      endcase
    end
  end

  assign OUTPUT_VALS = r_done ? ((w_reg & r_q) | (~w_reg & w_comb)) : '0;
  assign CFG_BUSY    = r_busy;
  assign CFG_DONE    = r_done;
  assign DBG_STATE   = r_state;

`ifdef PAL_MACROCELL_READBACK_EN
  assign CFG_OUT = r_chain[L-1];
`endif

endmodule

// File: tb/tb_pal_macrocell.sv
// Directed bench for pal_macrocell at N=2, P=2, M=1 (12-bit frame).
// Frame bit positions: AND p+k*P (k=2i true, 2i+1 complement), OR 8+p, REG 10, INV 11.
module tb_pal_macrocell;

  localparam int N = 2;
  localparam int P = 2;
  localparam int M = 1;
  localparam int L = 12;

  logic         CLK;
  logic         RES_N;
  logic         CFG_START;
  logic         CFG_VALID;
  logic         CFG_BIT;
  logic [N-1:0] INPUT_VARS;
  logic [M-1:0] OUTPUT_VALS;
  logic         CFG_BUSY;
  logic         CFG_DONE;
  logic [1:0]   DBG_STATE;
`ifdef PAL_MACROCELL_READBACK_EN
  logic         CFG_OUT;
`endif

  pal_macrocell #(.N(N), .P(P), .M(M)) dut (
    .CLK        (CLK),
    .RES_N      (RES_N),
    .CFG_START  (CFG_START),
    .CFG_VALID  (CFG_VALID),
    .CFG_BIT    (CFG_BIT),
    .INPUT_VARS (INPUT_VARS),
    .OUTPUT_VALS(OUTPUT_VALS),
    .CFG_BUSY   (CFG_BUSY),
    .CFG_DONE   (CFG_DONE),
    .DBG_STATE  (DBG_STATE)
`ifdef PAL_MACROCELL_READBACK_EN
    ,
    .CFG_OUT    (CFG_OUT)
`endif
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // F1: p0 = in0 & ~in1 (bits 0, 6), m0 <- p0 (bit 8), comb, true polarity
  localparam logic [L-1:0] F1 = 12'h141;
  // F2: F1 with REG (bit 10) and INV (bit 11)
  localparam logic [L-1:0] F2 = 12'hD41;
  // F3: p0 as F1, p1 = in1 (bit 5), m0 <- p0 | p1 -> in0 | in1
  localparam logic [L-1:0] F3 = 12'h361;
  // F4: m0 <- p0 but p0 has no literals -> 0
  localparam logic [L-1:0] F4 = 12'h100;
  // F5: F4 inverted -> 1
  localparam logic [L-1:0] F5 = 12'h900;
  // F6: no OR connection, inverted -> 1
  localparam logic [L-1:0] F6 = 12'h800;

  typedef struct {
    logic [L-1:0] frame;
    logic [N-1:0] in;
    logic [M-1:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks: inputs change 1ns after the rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_frame();
    CFG_START = 1'b1;
    tick();
    CFG_START = 1'b0;
  endtask

  task automatic shift_bit(input logic b);
    CFG_VALID = 1'b1;
    CFG_BIT   = b;
    tick();
    CFG_VALID = 1'b0;
  endtask

  task automatic load_frame(input logic [L-1:0] f);
    start_frame();
    for (int i = L-1; i >= 0; i--) shift_bit(f[i]);
  endtask

  initial begin
    logic [L-1:0] cur;

    vecs[0]  = '{F1, 2'b01, 1'b1};
    vecs[1]  = '{F1, 2'b11, 1'b0};
    vecs[2]  = '{F1, 2'b00, 1'b0};
    vecs[3]  = '{F1, 2'b10, 1'b0};
    vecs[4]  = '{F3, 2'b00, 1'b0};
    vecs[5]  = '{F3, 2'b01, 1'b1};
    vecs[6]  = '{F3, 2'b10, 1'b1};
    vecs[7]  = '{F3, 2'b11, 1'b1};
    vecs[8]  = '{F4, 2'b01, 1'b0};
    vecs[9]  = '{F4, 2'b11, 1'b0};
    vecs[10] = '{F5, 2'b01, 1'b1};
    vecs[11] = '{F5, 2'b00, 1'b1};
    vecs[12] = '{F6, 2'b10, 1'b1};
    vecs[13] = '{F6, 2'b01, 1'b1};

    RES_N      = 1'b0;
    CFG_START  = 1'b0;
    CFG_VALID  = 1'b0;
    CFG_BIT    = 1'b0;
    INPUT_VARS = 2'b01;
    #12;
    chk("reset_out", OUTPUT_VALS, 1'b0);
    chk("reset_busy", CFG_BUSY, 1'b0);
    chk("reset_done", CFG_DONE, 1'b0);
    tick();
    RES_N = 1'b1;
    tick();
    tick();
    chk("uncfg_out", OUTPUT_VALS, 1'b0);
    chk("uncfg_done", CFG_DONE, 1'b0);
    chk("uncfg_busy", CFG_BUSY, 1'b0);
    // valid bits outside LOAD must not start or advance anything
    shift_bit(1'b1);
    chk("uncfg_valid_ignored", CFG_BUSY, 1'b0);

    // first load: done only after the 12th bit
    start_frame();
    chk("load_busy", CFG_BUSY, 1'b1);
    for (int i = L-1; i >= 1; i--) shift_bit(F1[i]);
    chk("load_done_before_last", CFG_DONE, 1'b0);
    shift_bit(F1[0]);
    chk("load_done", CFG_DONE, 1'b1);
    chk("load_busy_clear", CFG_BUSY, 1'b0);

    // table-driven combinational checks
    cur = F1;
    for (int v = 0; v < 14; v++) begin
      if (vecs[v].frame !== cur) begin
        load_frame(vecs[v].frame);
        cur = vecs[v].frame;
      end
      INPUT_VARS = vecs[v].in;
      #1;
      chk($sformatf("vec%0d", v), OUTPUT_VALS, vecs[v].exp);
    end

    // registered, inverted macrocell: one cycle of latency
    load_frame(F2);
    INPUT_VARS = 2'b00;
    #1;
    chk("reg_before_clk", OUTPUT_VALS, 1'b0);
    tick();
    chk("reg_q_one", OUTPUT_VALS, 1'b1);
    INPUT_VARS = 2'b01;
    #1;
    chk("reg_hold", OUTPUT_VALS, 1'b1);
    tick();
    chk("reg_q_zero", OUTPUT_VALS, 1'b0);
    INPUT_VARS = 2'b00;
    tick();
    chk("reg_q_one_again", OUTPUT_VALS, 1'b1);
    // CFG_START from RUN clears the flop and gates outputs
    start_frame();
    chk("restart_out", OUTPUT_VALS, 1'b0);
    chk("restart_busy", CFG_BUSY, 1'b1);
    chk("restart_done", CFG_DONE, 1'b0);
    for (int i = L-1; i >= 0; i--) shift_bit(F2[i]);
    #1;
    chk("reg_flop_cleared", OUTPUT_VALS, 1'b0);

    // gapped load of F1 with live inputs that would drive output 1
    INPUT_VARS = 2'b01;
    start_frame();
    for (int j = 0; j < L; j++) begin
      shift_bit(F1[L-1-j]);
      if (j < L-1) begin
        chk("gap_busy", CFG_BUSY, 1'b1);
        chk("gap_done", CFG_DONE, 1'b0);
        chk("gap_out", OUTPUT_VALS, 1'b0);
        tick();
        chk("gap_idle_busy", CFG_BUSY, 1'b1);
        chk("gap_idle_out", OUTPUT_VALS, 1'b0);
      end
    end
    chk("gap_done_final", CFG_DONE, 1'b1);
    chk("gap_out_final", OUTPUT_VALS, 1'b1);

    // CFG_VALID in RUN is ignored
    for (int i = 0; i < 3; i++) shift_bit(1'b1);
    chk("run_valid_done", CFG_DONE, 1'b1);
    chk("run_valid_out", OUTPUT_VALS, 1'b1);

    // CFG_START at bit 7 restarts; the bit offered with START is discarded
    start_frame();
    for (int i = 0; i < 7; i++) shift_bit(1'b1);
    CFG_START = 1'b1;
    CFG_VALID = 1'b1;
    CFG_BIT   = 1'b1;
    tick();
    CFG_START = 1'b0;
    CFG_VALID = 1'b0;
    chk("mid_restart_busy", CFG_BUSY, 1'b1);
    for (int i = L-1; i >= 1; i--) shift_bit(F1[i]);
    chk("mid_restart_not_done", CFG_DONE, 1'b0);
    shift_bit(F1[0]);
    chk("mid_restart_done", CFG_DONE, 1'b1);
    chk("mid_restart_out", OUTPUT_VALS, 1'b1);

    // reset mid-frame after 5 bits of ones
    start_frame();
    for (int i = 0; i < 5; i++) shift_bit(1'b1);
    RES_N = 1'b0;
    #1;
    chk("midrst_out", OUTPUT_VALS, 1'b0);
    chk("midrst_busy", CFG_BUSY, 1'b0);
    chk("midrst_done", CFG_DONE, 1'b0);
    tick();
    RES_N = 1'b1;
    tick();
    chk("midrst_uncfg_busy", CFG_BUSY, 1'b0);
`ifdef PAL_MACROCELL_READBACK_EN
    // a cleared chain reads back as all zeros
    start_frame();
    for (int j = 0; j < L; j++) begin
      chk("midrst_chain_zero", CFG_OUT, 1'b0);
      shift_bit(1'b0);
    end
`endif
    load_frame(F1);
    chk("midrst_fresh_done", CFG_DONE, 1'b1);
    chk("midrst_fresh_out", OUTPUT_VALS, 1'b1);

`ifdef PAL_MACROCELL_READBACK_EN
    // loading F2 over F1 returns F1 MSB first
    start_frame();
    for (int j = 0; j < L; j++) begin
      chk($sformatf("readback_bit%0d", L-1-j), CFG_OUT, F1[L-1-j]);
      shift_bit(F2[L-1-j]);
    end
    chk("readback_done", CFG_DONE, 1'b1);
`endif

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
